// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory port and the memory responder.
interface mem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              mem_req_valid_i;
  logic              mem_req_ready_o;
  logic [ADDR_W-1:0] mem_adres_i;
  logic              mem_we_i;
  logic [3:0]        mem_wstrb_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic              mem_resp_valid_o;
  logic              mem_resp_ready_i;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              mem_err_o;

  modport master (
    output mem_req_valid_i, mem_adres_i, mem_we_i, mem_wstrb_i, mem_wdata_i, mem_resp_ready_i,
    input  mem_req_ready_o, mem_resp_valid_o, mem_rdata_o, mem_err_o
  );

  modport slave (
    input  mem_req_valid_i, mem_adres_i, mem_we_i, mem_wstrb_i, mem_wdata_i, mem_resp_ready_i,
    output mem_req_ready_o, mem_resp_valid_o, mem_rdata_o, mem_err_o
  );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits LATENCY
// cycles, performs the access on a word RAM and holds the response until taken.
module mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  mem_responder_if.slave  bus
);

  localparam int                IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_L  = ADDR_W'(DEPTH_WORDS);
  localparam logic [3:0]        CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] a_adres;
  logic              a_we;
  logic [3:0]        a_wstrb;
  logic [DATA_W-1:0] a_wdata;
  logic              resp_valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [DATA_W-1:0] ram [DEPTH_WORDS];

  logic [ADDR_W-1:0] word_idx;
  logic              acc_err;
  logic              commit;

  // Decode the latched address and flag the commit cycle.
  always_comb begin
    word_idx = {2'b00, a_adres[ADDR_W-1:2]};
    acc_err  = (a_adres[1:0] != 2'b00) || (word_idx >= DEPTH_L);
    commit   = (state == WAIT) && (cnt == 4'd0);
  end

  assign bus.mem_req_ready_o  = rst_i && (state == IDLE);
  assign bus.mem_resp_valid_o = resp_valid_q;
  assign bus.mem_rdata_o      = rdata_q;
  assign bus.mem_err_o        = err_q;

  // Byte-masked RAM write at the commit edge; reset in that cycle suppresses it.
  always_ff @(posedge clk_i) begin
    if (rst_i && commit && a_we && !acc_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (a_wstrb[b]) ram[word_idx[IDX_W-1:0]][8*b +: 8] <= a_wdata[8*b +: 8];
      end
    end
  end

  // Transaction FSM with registered response outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_req_valid_i) begin
            a_adres <= bus.mem_adres_i;
            a_we    <= bus.mem_we_i;
            a_wstrb <= bus.mem_wstrb_i;
            a_wdata <= bus.mem_wdata_i;
            cnt     <= CNT_INIT;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            resp_valid_q <= 1'b1;
            err_q        <= acc_err;
            rdata_q      <= (acc_err || a_we) ? '0 : ram[word_idx[IDX_W-1:0]];
            state        <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.mem_resp_ready_i) begin
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the processor's data/instruction memory port. It accepts single-beat read and write requests from the core over a valid/ready handshake. After a programmable latency it performs the access on an internal word-organised RAM and returns a response on a second valid/ready channel. It is the other end of the core's `mem_adres_i` interface and serves as the simulation/FPGA main memory behind the pipeline.

## Interface
- `DATA_W`, 32, data width; fixed at 32, one word = 4 bytes
- `ADDR_W`, 32, byte address width
- `DEPTH_WORDS`, 1024, RAM depth in 32-bit words
- `LATENCY`, 2, accept-to-response delay in cycles; legal range 1..16
- `clk_i` in 1: single clock; all logic on the rising edge
- `rst_i` in 1: reset, synchronous, active-low
- `mem_req_valid_i` in 1: request valid
- `mem_req_ready_o` out 1: responder can accept a request
- `mem_adres_i` in ADDR_W: byte address
- `mem_we_i` in 1: 1 = write, 0 = read
- `mem_wstrb_i` in 4: byte-enable for writes; bit n covers `wdata[8n+7:8n]`
- `mem_wdata_i` in DATA_W: write data
- `mem_resp_valid_o` out 1: response valid
- `mem_resp_ready_i` in 1: requester accepts the response
- `mem_rdata_o` out DATA_W: read data; 0 for writes and errors
- `mem_err_o` out 1: access error, valid with `mem_resp_valid_o`

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `mem_req_ready_o = rst_i` (high only in IDLE and out of reset).
  - On `mem_req_valid_i & mem_req_ready_o` at an edge, latch address, we, wstrb and wdata.
  - Load the 4-bit down-counter with `LATENCY-1` and go to WAIT.
- WAIT:
  - Decrement the counter each edge.
  - At the edge where the counter is 0, perform the access and go to RESP.
- Access:
  - Word index = `adres[ADDR_W-1:2]`.
  - An error occurs if `adres[1:0] != 0` (misaligned) or the index is ≥ `DEPTH_WORDS`.
  - Error: no RAM write, `rdata = 0`, `err = 1`.
  - Read: `rdata` = RAM[index], `err = 0`.
  - Write: each byte with its strobe set is updated; bytes with the strobe clear are unchanged. `rdata = 0`, `err = 0`. A write with all strobes clear is a legal no-op.
- RESP:
  - `mem_resp_valid_o = 1`; `rdata`/`err` are registered and held stable until handshake.
  - On `mem_resp_ready_i` at an edge, go to IDLE and clear `resp_valid`, `rdata` and `err`.
- Requests presented outside IDLE are not accepted (ready low). The requester holds them.
- One outstanding transaction maximum; no reordering.
- RAM contents are not reset. They are initialised only by `$readmemh` in simulation.

## Timing
- Reset: while `rst_i` is low at an edge, state goes to IDLE and the counter to 0. After that edge: `mem_req_ready_o = 0` while `rst_i` stays low, then 1; `mem_resp_valid_o = 0`; `mem_rdata_o = 0`; `mem_err_o = 0`.
- Reset mid-transaction (WAIT or RESP): the transaction is dropped with no response. A write in WAIT that has not reached its commit edge is never performed. A write already committed stays committed.
- Latency: request accepted at edge k → `mem_resp_valid_o` high from edge k+LATENCY.
- `mem_resp_ready_i` already high in the first RESP cycle → handshake at edge k+LATENCY+1.
- Earliest next accept is edge k+LATENCY+2. Peak throughput is 1 transaction per LATENCY+2 cycles.
- Backpressure: `resp_valid`, `rdata` and `err` stay constant for any number of cycles with `mem_resp_ready_i` low.
- `mem_req_ready_o` depends only on state and `rst_i`, never combinationally on `mem_req_valid_i`.
- `mem_resp_valid_o` never depends combinationally on `mem_resp_ready_i`.
- Write-then-read of the same word: the read returns the new data.

## Test plan
- Reset then write `0x0000_0010`, data `0xDEADBEEF`, strobe `4'hF`; read `0x10` → resp_valid at accept+LATENCY, `rdata = 0xDEADBEEF`, `err = 0`.
- Partial strobe: over `0xDEADBEEF` at `0x10`, write `0x00001122` with strobe `4'b0011`; read → `0xDEAD1122`.
- Errors:
  - Read `0x12` (misaligned) → `err = 1`, `rdata = 0`.
  - Write to `4*DEPTH_WORDS` → `err = 1`; a read of word 0 confirms no aliasing write occurred.
- Backpressure: hold `mem_resp_ready_i` low 3 cycles → response stable 4 cycles, `mem_req_ready_o` low throughout; next accept exactly 1 cycle after handshake.
- Reset mid-WAIT (LATENCY=4, write to `0x20`, `rst_i` low 1 cycle at accept+2) → no response; a later read of `0x20` returns the old value.
- Sweep LATENCY=1 and 16 with back-to-back valid held high → accept spacing equals LATENCY+2 cycles.
